nbit_serial_logic: RTL and testbench
====================================

NBIT_SERIAL_LOGIC -- requirements
Module: nbit_serial_logic

Interface
REQ-001 The block SHALL have parameter N, default 32, which sets the operand and result width in bits.
REQ-002 The block SHALL have input clk, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have input start, 1 bit: request to begin an operation.
REQ-005 The block SHALL have input op, 2 bits: operation select; 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-006 The block SHALL have inputs inval1 and inval2, N bits each: the operands.
REQ-007 The block SHALL have output outval, N bits: registered result.
REQ-008 The block SHALL have output busy, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have output done, 1 bit: a one-cycle completion pulse.

Function
REQ-010 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE, start=1 at a rising edge SHALL capture inval1, inval2 and op into internal registers, clear the bit counter to 0 and enter RUN.
REQ-012 In IDLE, start=0 SHALL leave the FSM in IDLE with all registers held.
REQ-013 RUN SHALL process exactly one bit per cycle, LSB first: at each edge, result bit[cnt] = op(a[cnt], b[cnt]) and cnt increments by 1.
REQ-014 The operation applied SHALL be the op captured at start; changes on op, inval1 or inval2 during RUN SHALL NOT affect the result.
REQ-015 On the edge that processes bit N-1, the full result SHALL be loaded into outval and the FSM SHALL enter DONE.
REQ-016 The counter SHALL be ceil(log2(N)) bits wide, at least 1, and SHALL NOT wrap during RUN.
REQ-017 The FSM SHALL remain in DONE for exactly one cycle and then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly when the state is RUN.
REQ-019 done SHALL be 1 exactly when the state is DONE.
REQ-020 Latency: if start is accepted at edge E0, done SHALL be high in the cycle following edge E_N, and outval SHALL be valid from E_N onward.
REQ-021 start SHALL be ignored in RUN and DONE; it is not queued, and the earliest next acceptance is the first edge in IDLE.
REQ-022 outval SHALL hold its last completed result until the next completion or a reset, and SHALL NOT show partial results during RUN.
REQ-023 NOR SHALL be computed per bit as the inverse of OR; no other encodings exist.

Reset
REQ-024 While reset=1, the block SHALL immediately, without waiting for clk, force state to IDLE, outval to 0, busy to 0, done to 0, counter to 0, and the captured operand and op registers to 0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse and outval=0.
REQ-026 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (N=8)
REQ-027 The bench SHALL cover: reset, then op=01, inval1=0xA5, inval2=0x0F, start pulse -> busy high for 8 cycles, done pulse on cycle 9, outval=0xAF.
REQ-028 The bench SHALL cover: op=00, 0xF0 and 0x3C -> outval=0x30; op=10, 0xFF and 0x0F -> outval=0xF0; op=11, 0x00 and 0x00 -> outval=0xFF.
REQ-029 The bench SHALL cover: start held high continuously -> operations back-to-back with one DONE cycle and one IDLE cycle between them, and each result correct.
REQ-030 The bench SHALL cover: inval1, inval2 and op changed mid-RUN -> outval matches the values captured at start.
REQ-031 The bench SHALL cover: reset asserted asynchronously at RUN cycle 4 -> outputs go to 0 immediately and no done pulse occurs; the next start completes normally.
REQ-032 The bench SHALL cover: start asserted in DONE -> ignored, FSM returns to IDLE, and no new operation begins.

Source files
------------

// File: rtl/nbit_serial_logic.sv
// nbit_serial_logic: bit-serial AND/OR/XOR/NOR of two N-bit operands, one bit per clock, LSB first.
module nbit_serial_logic #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inval1,
  input  logic [N-1:0] inval2,
  output logic [N-1:0] outval,
  output logic         busy,
  output logic         done
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    state;
  logic [1:0]    op_r;
  logic [N-1:0]  a, b, acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic          bit_res, last;
  always_comb begin
    bit_res = op_r == 2'b00 ? a[cnt] & b[cnt] :
              op_r == 2'b01 ? a[cnt] | b[cnt] :
              op_r == 2'b10 ? a[cnt] ^ b[cnt] : ~(a[cnt] | b[cnt]);
    acc_nxt = acc;
    acc_nxt[cnt] = bit_res;
    last = cnt == CW'(N - 1);
  end
  // acc collects partial bits privately so outval only ever shows complete results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= '0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
      outval <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a     <= inval1;
        b     <= inval2;
        op_r  <= op;
        acc   <= '0;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      acc <= acc_nxt;
      if (last) begin
        outval <= acc_nxt;
        state  <= DONE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      state <= IDLE;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_nbit_serial_logic.sv
// tb_nbit_serial_logic: directed checks of nbit_serial_logic with N=8.
module tb_nbit_serial_logic;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] inval1 = 8'h00, inval2 = 8'h00;
  logic [7:0] outval;
  logic       busy, done;
  int         checks = 0, failures = 0;

  nbit_serial_logic #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .inval1(inval1), .inval2(inval2),
    .outval(outval), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++;
    if ({outval, busy, done} !== 10'h000) begin
      failures++;
      $display("FAIL reset_async outval=%h busy=%b done=%b want 00 0 0", outval, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({outval, busy, done} !== 10'h000) begin
      failures++;
      $display("FAIL reset_idle outval=%h busy=%b done=%b want 00 0 0", outval, busy, done);
    end
  endtask

  task automatic test_ops();
    logic [1:0] t_op [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [7:0] t_a  [4] = '{8'hA5, 8'hF0, 8'hFF, 8'h00};
    logic [7:0] t_b  [4] = '{8'h0F, 8'h3C, 8'h0F, 8'h00};
    logic [7:0] t_e  [4] = '{8'hAF, 8'h30, 8'hF0, 8'hFF};
    logic [7:0] prev;
    int nbusy;
    for (int k = 0; k < 4; k++) begin
      prev = outval;
      op = t_op[k]; inval1 = t_a[k]; inval2 = t_b[k]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 8; i++) begin
        nbusy += (busy === 1'b1 && done === 1'b0 && outval === prev) ? 1 : 0;
        @(negedge clk);
      end
      checks++;
      if (nbusy != 8) begin
        failures++;
        $display("FAIL op%0d_busy good_busy_cycles=%0d want 8", k, nbusy);
      end
      checks++;
      if ({done, busy, outval} !== {2'b10, t_e[k]}) begin
        failures++;
        $display("FAIL op%0d_done done=%b busy=%b outval=%h want 1 0 %h", k, done, busy, outval, t_e[k]);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, outval} !== {2'b00, t_e[k]}) begin
        failures++;
        $display("FAIL op%0d_idle done=%b busy=%b outval=%h want 0 0 %h", k, done, busy, outval, t_e[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    op = 2'b10; inval1 = 8'h55; inval2 = 8'h0F; start = 1'b1;
    repeat (9) @(negedge clk);
    checks++;
    if ({done, outval} !== {1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL b2b_first done=%b outval=%h want 1 5a", done, outval);
    end
    op = 2'b00; inval1 = 8'hCC; inval2 = 8'hAA;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_gap done=%b busy=%b want 0 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart busy=%b want 1", busy);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({done, outval} !== {1'b1, 8'h88}) begin
      failures++;
      $display("FAIL b2b_second done=%b outval=%h want 1 88", done, outval);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_run_change();
    op = 2'b01; inval1 = 8'h12; inval2 = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op = 2'b11; inval1 = 8'h00; inval2 = 8'h00; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, outval} !== {1'b1, 8'h52}) begin
      failures++;
      $display("FAIL mid_run done=%b outval=%h want 1 52", done, outval);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int ndone;
    op = 2'b10; inval1 = 8'h3C; inval2 = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({outval, busy, done} !== 10'h000) begin
      failures++;
      $display("FAIL abort_async outval=%h busy=%b done=%b want 00 0 0", outval, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ndone += (done === 1'b1 || busy === 1'b1) ? 1 : 0;
    end
    checks++;
    if (ndone != 0 || outval !== 8'h00) begin
      failures++;
      $display("FAIL abort_quiet active_cycles=%0d outval=%h want 0 00", ndone, outval);
    end
    op = 2'b11; inval1 = 8'h0F; inval2 = 8'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({done, outval} !== {1'b1, 8'hC0}) begin
      failures++;
      $display("FAIL abort_recover done=%b outval=%h want 1 c0", done, outval);
    end
    @(negedge clk);
  endtask

  task automatic test_start_in_done();
    op = 2'b00; inval1 = 8'h0F; inval2 = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({done, outval} !== {1'b1, 8'h07}) begin
      failures++;
      $display("FAIL sid_done done=%b outval=%h want 1 07", done, outval);
    end
    op = 2'b01; inval1 = 8'hF0; inval2 = 8'hF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL sid_idle done=%b busy=%b want 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, outval} !== {2'b00, 8'h07}) begin
      failures++;
      $display("FAIL sid_ignored done=%b busy=%b outval=%h want 0 0 07", done, busy, outval);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_mid_run_change();
    test_reset_abort();
    test_start_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
